afifo_wr_arb: RTL

- Round-robin arbiter that shares the write port of one asynchronous FIFO (77-bit, depth-2 class) among N requesters on the FIFO write-clock domain.
- Grants one requester at a time and locks the grant for a burst. The burst ends on the requester's last flag or after MAX_BURST beats.
- Drives the FIFO's wr_en/wr_data and honours its registered full flag, so no overflow is ever issued.
- Sits between the producer blocks and the FIFO write side.

---
 rtl/afifo_wr_arb.sv | 104 ++++++++++
 1 files changed

// File: rtl/afifo_wr_arb.sv
// Round-robin arbiter sharing one async-FIFO write port among N requesters; grant locks for a burst.
// Grant lands the cycle after a request in IDLE; beats stall while the registered full flag is high.
module afifo_wr_arb #(
  parameter int W         = 77,
  parameter int N         = 4,
  parameter int IW        = 2,
  parameter int MAX_BURST = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           fifo_wr_en,
  output logic [W-1:0]   fifo_wr_data,
  input  logic           fifo_wr_full,
  input  logic           fifo_wr_afull,
  output logic [IW-1:0]  grant_id,
  output logic           busy,
  output logic [15:0]    beats_cnt
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [7:0]    burst_cnt;
  logic [15:0]   afull_cycles;
  logic [W-1:0]  data_arr [N];
  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   cand;
  logic          locked;
  logic          end_burst;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*W +: W];
  end

  // Scan rr_ptr+1 .. rr_ptr+N with an explicit wrap so non-power-of-two N works.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req_valid[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  assign locked       = (state == LOCK) && !reset;
  assign fifo_wr_en   = locked && req_valid[grant_id] && !fifo_wr_full;
  assign fifo_wr_data = data_arr[grant_id];
  assign busy         = (state == LOCK);
  assign end_burst    = req_last[grant_id] || (burst_cnt == 8'(MAX_BURST-1));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = locked && (grant_id == IW'(i)) && !fifo_wr_full;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant_id     <= '0;
      rr_ptr       <= IW'(N-1);
      burst_cnt    <= '0;
      beats_cnt    <= '0;
      afull_cycles <= '0;
    end else begin
      if (fifo_wr_afull && afull_cycles != 16'hFFFF) afull_cycles <= afull_cycles + 16'd1;
      if (fifo_wr_en && beats_cnt != 16'hFFFF) beats_cnt <= beats_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= pick;
            burst_cnt <= '0;
            state     <= LOCK;
          end
        end
        LOCK: begin
          if (fifo_wr_en) begin
            burst_cnt <= burst_cnt + 8'd1;
            if (end_burst) begin
              state  <= IDLE;
              rr_ptr <= grant_id;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (reset) !(fifo_wr_en && fifo_wr_full));

endmodule
